// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle between the multiplier-side producer and bin2bcd_seq.
// master: upstream driver of in_valid/bin; slave: the converter itself.
interface bin2bcd_seq_if #(
  parameter int W      = 10,
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic [W-1:0]          bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  out_valid;
  logic                  busy;
  logic                  overflow;

  modport master (
    output in_valid, bin,
    input  bcd, out_valid, busy, overflow
  );

  modport slave (
    input  in_valid, bin,
    output bcd, out_valid, busy, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking of the stored result: define BCD_BLANK_EN.
module bin2bcd_seq #(
  parameter int W      = 10,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic               in_valid_d;
  logic [W-1:0]       sreg, sreg_nxt;
  logic [BCD_W-1:0]   scratch, scratch_nxt;
  logic               ovf_acc, ovf_acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BCD_W-1:0]   bcd_q, bcd_nxt;
  logic               ovf_q, ovf_nxt;
  logic               out_valid_q, out_valid_nxt;
  logic [BCD_W-1:0]   adj;
  logic               start_evt;

  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] finish_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
`ifdef BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      // Walk down from the top digit; digit 0 always stays visible.
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (s[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
        else                               lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  assign start_evt = bus.in_valid & ~in_valid_d;
  assign adj       = dabble_adj(scratch);

  always_comb begin
    state_nxt     = state;
    sreg_nxt      = sreg;
    scratch_nxt   = scratch;
    ovf_acc_nxt   = ovf_acc;
    cnt_nxt       = cnt;
    bcd_nxt       = bcd_q;
    ovf_nxt       = ovf_q;
    out_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_evt) begin
          sreg_nxt    = bus.bin;
          scratch_nxt = '0;
          ovf_acc_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // Any bit carried out of the top digit means value >= 10^DIGITS.
        ovf_acc_nxt              = ovf_acc | adj[BCD_W-1];
        {scratch_nxt, sreg_nxt}  = {adj[BCD_W-2:0], sreg, 1'b0};
        cnt_nxt                  = cnt + 1'b1;
        if (cnt == CNT_W'(W - 1)) state_nxt = DONE;
      end
      DONE: begin
        bcd_nxt       = finish_digits(scratch);
        ovf_nxt       = ovf_acc;
        out_valid_nxt = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_valid_d  <= 1'b0;
      sreg        <= '0;
      scratch     <= '0;
      ovf_acc     <= 1'b0;
      cnt         <= '0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_valid_d  <= bus.in_valid;
      sreg        <= sreg_nxt;
      scratch     <= scratch_nxt;
      ovf_acc     <= ovf_acc_nxt;
      cnt         <= cnt_nxt;
      bcd_q       <= bcd_nxt;
      ovf_q       <= ovf_nxt;
      out_valid_q <= out_valid_nxt;
    end
  end

  // The result cycle (back in IDLE) still counts as busy, so a new start
  // can only be accepted on the edge after out_valid.
  assign bus.bcd       = bcd_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state != IDLE) | out_valid_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: W=10 with DIGITS=4 and DIGITS=2 side by side.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [9:0] bin;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int pulses4 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq_if #(.W(10), .DIGITS(4)) bus4();
  bin2bcd_seq_if #(.W(10), .DIGITS(2)) bus2();

  assign bus4.in_valid = in_valid;
  assign bus4.bin      = bin;
  assign bus2.in_valid = in_valid;
  assign bus2.bin      = bin;

  bin2bcd_seq #(.W(10), .DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  bin2bcd_seq #(.W(10), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [9:0]  bin;
    logic [15:0] e4;
    logic        o4;
    logic [7:0]  e2;
    logic        o2;
  } vec_t;

  exp_t q4[$];
  exp_t q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] shown(input logic [15:0] raw, input int digits);
    logic [15:0] r;
    r = raw;
`ifdef BCD_BLANK_EN
    begin
      bit lead;
      lead = 1'b1;
      for (int i = digits - 1; i >= 1; i--) begin
        if (lead && (r[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
        else                               lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Called at tick time right before the start edge: pulse is seen 12 ticks later.
  task automatic push(input logic [15:0] e4, input logic o4, input logic [7:0] e2, input logic o2);
    exp_t e;
    e.bcd = shown(e4, 4); e.ovf = o4; e.cyc = cyc + 12;
    q4.push_back(e);
    e.bcd = shown({8'h00, e2}, 2); e.ovf = o2;
    q2.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q4.size() != 0 || q2.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain4", q4.size(), 0);
    check("drain2", q2.size(), 0);
    q4.delete();
    q2.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus4.out_valid) begin
        pulses4++;
        if (q4.size() == 0) begin
          tests++; fails++;
          $display("FAIL pulse4: got unexpected out_valid, required none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q4.pop_front();
          check("bcd4", 32'(bus4.bcd), 32'(e.bcd));
          check("ovf4", 32'(bus4.overflow), 32'(e.ovf));
          check("lat4", cyc, e.cyc);
        end
      end
      if (bus2.out_valid) begin
        if (q2.size() == 0) begin
          tests++; fails++;
          $display("FAIL pulse2: got unexpected out_valid, required none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q2.pop_front();
          check("bcd2", 32'(bus2.bcd), 32'(e.bcd[7:0]));
          check("ovf2", 32'(bus2.overflow), 32'(e.ovf));
          check("lat2", cyc, e.cyc);
        end
      end
    end
  end

  vec_t vecs[10];

  initial begin
    int n;
    int p;
    vecs[0] = '{10'd961,  16'h0961, 1'b0, 8'h61, 1'b1};
    vecs[1] = '{10'd0,    16'h0000, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{10'd1023, 16'h1023, 1'b0, 8'h23, 1'b1};
    vecs[3] = '{10'd9,    16'h0009, 1'b0, 8'h09, 1'b0};
    vecs[4] = '{10'd512,  16'h0512, 1'b0, 8'h12, 1'b1};
    vecs[5] = '{10'd99,   16'h0099, 1'b0, 8'h99, 1'b0};
    vecs[6] = '{10'd100,  16'h0100, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{10'd1000, 16'h1000, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{10'd5,    16'h0005, 1'b0, 8'h05, 1'b0};
    vecs[9] = '{10'd77,   16'h0077, 1'b0, 8'h77, 1'b0};

    rst = 1'b1; in_valid = 1'b0; bin = '0;
    repeat (3) tick();
    check("rst_bcd4", 32'(bus4.bcd), 0);
    check("rst_ovf2", 32'(bus2.overflow), 0);
    check("rst_vld4", 32'(bus4.out_valid), 0);
    check("rst_busy4", 32'(bus4.busy), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Latency and busy window on a single conversion.
    n = cyc;
    bin = 10'd961; in_valid = 1'b1;
    push(16'h0961, 1'b0, 8'h61, 1'b1);
    tick();
    check("busy_start", 32'(bus4.busy), 1);
    in_valid = 1'b0;
    while (cyc < n + 12) tick();
    check("busy_result_cycle", 32'(bus4.busy), 1);
    tick();
    check("busy_fall", 32'(bus4.busy), 0);
    wait_drain(5);

    for (int i = 0; i < 10; i++) begin
      bin = vecs[i].bin; in_valid = 1'b1;
      push(vecs[i].e4, vecs[i].o4, vecs[i].e2, vecs[i].o2);
      tick();
      in_valid = 1'b0;
      wait_drain(30);
      tick();
    end

    // in_valid held high: exactly one conversion.
    p = pulses4;
    bin = 10'd961; in_valid = 1'b1;
    push(16'h0961, 1'b0, 8'h61, 1'b1);
    repeat (40) tick();
    check("held_pulses", pulses4 - p, 1);
    in_valid = 1'b0;
    wait_drain(5);
    repeat (2) tick();

    // A second rising edge mid-conversion is ignored; a later one is honoured.
    p = pulses4;
    bin = 10'd512; in_valid = 1'b1;
    push(16'h0512, 1'b0, 8'h12, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    bin = 10'd333; in_valid = 1'b1;
    wait_drain(30);
    n = 0;
    while (bus4.busy && n < 5) begin tick(); n++; end
    check("busy_released", 32'(bus4.busy), 0);
    in_valid = 1'b0;
    tick();
    bin = 10'd77; in_valid = 1'b1;
    push(16'h0077, 1'b0, 8'h77, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_drain(30);
    check("reedge_pulses", pulses4 - p, 2);
    repeat (2) tick();

    // Back-to-back at minimum spacing: pulses exactly 12 clocks apart.
    n = cyc;
    bin = 10'd9; in_valid = 1'b1;
    push(16'h0009, 1'b0, 8'h09, 1'b0);
    tick();
    in_valid = 1'b0;
    while (cyc < n + 12) tick();
    bin = 10'd512; in_valid = 1'b1;
    push(16'h0512, 1'b0, 8'h12, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_drain(30);
    repeat (2) tick();

    // Asynchronous reset mid-shift, released with in_valid still high.
    bin = 10'd200; in_valid = 1'b1;
    push(16'h0200, 1'b0, 8'h00, 1'b1);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("arst_bcd4", 32'(bus4.bcd), 0);
    check("arst_bcd2", 32'(bus2.bcd), 0);
    check("arst_ovf2", 32'(bus2.overflow), 0);
    check("arst_busy4", 32'(bus4.busy), 0);
    check("arst_vld4", 32'(bus4.out_valid), 0);
    q4.delete();
    q2.delete();
    bin = 10'd77;
    tick();
    rst = 1'b0;
    push(16'h0077, 1'b0, 8'h77, 1'b0);
    wait_drain(30);
    in_valid = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
